adc_spi_reader: RTL and testbench

ADC_SPI_READER -- requirements
Module: adc_spi_reader

---
 rtl/adc_spi_reader.sv | 133 +++++++++++++
 tb/tb_adc_spi_reader.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/adc_spi_reader.sv
// Serial ADC frame reader: drives CS_N/SCLK, shifts in one frame per START,
// and presents the trailing DATA_BITS of the frame with a one-cycle valid pulse.
module adc_spi_reader #(
  parameter int SCLK_DIV     = 4,
  parameter int FRAME_BITS   = 16,
  parameter int DATA_BITS    = 12,
  parameter int QUIET_CYCLES = 8
) (
  input  logic                 INPUT_CLK,
  input  logic                 RESET,
  input  logic                 START,
  input  logic                 ADC_SDO,
  output logic                 ADC_CS_N,
  output logic                 ADC_SCLK,
  output logic [DATA_BITS-1:0] DATA_OUT,
  output logic                 DATA_VALID,
  output logic                 FRAME_ERR,
  output logic                 BUSY
);

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    SHIFT,
    HOLD,
    QUIET
  } state_t;

  state_t                state_q;
  state_t                state_d;
  logic [7:0]            tcnt_q;
  logic [7:0]            qcnt_q;
  logic [5:0]            bcnt_q;
  logic [FRAME_BITS-1:0] sreg_q;
  logic                  tick;
  logic                  qdone;
  logic                  cs_n_d;
  logic                  sclk_d;
  logic                  sample;
  logic                  load;

  assign tick  = (tcnt_q == 8'(SCLK_DIV - 1));
  assign qdone = (qcnt_q == 8'(QUIET_CYCLES - 1));
  assign BUSY  = (state_q != IDLE);

  always_comb begin
    state_d = state_q;
    cs_n_d  = ADC_CS_N;
    sclk_d  = ADC_SCLK;
    sample  = 1'b0;
    load    = 1'b0;
    unique case (state_q)
      IDLE: begin
        cs_n_d = 1'b1;
        sclk_d = 1'b1;
        if (START) begin
          state_d = SETUP;
          cs_n_d  = 1'b0;
        end
      end
      SETUP: begin
        if (tick) begin
          state_d = SHIFT;
          sclk_d  = 1'b0;
        end
      end
      SHIFT: begin
        // The final rising edge is not followed by a fall: SCLK parks high
        if (tick) begin
          if (!ADC_SCLK) begin
            sclk_d = 1'b1;
            sample = 1'b1;
          end else if (bcnt_q == 6'(FRAME_BITS)) begin
            state_d = HOLD;
          end else begin
            sclk_d = 1'b0;
          end
        end
      end
      HOLD: begin
        if (tick) begin
          state_d = QUIET;
          cs_n_d  = 1'b1;
          load    = 1'b1;
        end
      end
      QUIET: begin
        cs_n_d = 1'b1;
        sclk_d = 1'b1;
        if (qdone) state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        cs_n_d  = 1'b1;
        sclk_d  = 1'b1;
      end
    endcase
  end

  always_ff @(posedge INPUT_CLK or posedge RESET) begin
    if (RESET) begin
      state_q    <= IDLE;
      ADC_CS_N   <= 1'b1;
      ADC_SCLK   <= 1'b1;
      tcnt_q     <= '0;
      qcnt_q     <= '0;
      bcnt_q     <= '0;
      sreg_q     <= '0;
      DATA_OUT   <= '0;
      DATA_VALID <= 1'b0;
      FRAME_ERR  <= 1'b0;
    end else begin
      state_q    <= state_d;
      ADC_CS_N   <= cs_n_d;
      ADC_SCLK   <= sclk_d;
      DATA_VALID <= load;
      FRAME_ERR  <= load && (|sreg_q[FRAME_BITS-1:DATA_BITS]);
      if (state_d != state_q || tick) tcnt_q <= '0;
      else tcnt_q <= tcnt_q + 8'd1;
      if (state_d != state_q) qcnt_q <= '0;
      else if (state_q == QUIET) qcnt_q <= qcnt_q + 8'd1;
      if (state_q == IDLE) begin
        bcnt_q <= '0;
        sreg_q <= '0;
      end else if (sample) begin
        bcnt_q <= bcnt_q + 6'd1;
        sreg_q <= {sreg_q[FRAME_BITS-2:0], ADC_SDO};
      end
      if (load) DATA_OUT <= sreg_q[DATA_BITS-1:0];
    end
  end

endmodule

// File: tb/tb_adc_spi_reader.sv
// Directed bench for adc_spi_reader: default-divider and SCLK_DIV=1 instances,
// each fed by a behavioural ADC that shifts its word out on falling SCLK.
module tb_adc_spi_reader;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        start2 = 1'b0;
  logic        sdo = 1'b0;
  logic        sdo2 = 1'b0;
  logic        cs_n, sclk, valid, ferr, busy;
  logic        cs_n2, sclk2, valid2, ferr2, busy2;
  logic [11:0] data, data2;

  adc_spi_reader dut (
    .INPUT_CLK (clk),
    .RESET     (rst),
    .START     (start),
    .ADC_SDO   (sdo),
    .ADC_CS_N  (cs_n),
    .ADC_SCLK  (sclk),
    .DATA_OUT  (data),
    .DATA_VALID(valid),
    .FRAME_ERR (ferr),
    .BUSY      (busy)
  );

  adc_spi_reader #(.SCLK_DIV(1)) dut2 (
    .INPUT_CLK (clk),
    .RESET     (rst),
    .START     (start2),
    .ADC_SDO   (sdo2),
    .ADC_CS_N  (cs_n2),
    .ADC_SCLK  (sclk2),
    .DATA_OUT  (data2),
    .DATA_VALID(valid2),
    .FRAME_ERR (ferr2),
    .BUSY      (busy2)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [15:0] word1 = 16'h0;
  logic [15:0] word2 = 16'h0;
  int idx1 = 15;
  int idx2 = 15;

  always @(negedge cs_n) idx1 = 15;
  always @(negedge sclk) begin
    if (idx1 >= 0) sdo = word1[idx1];
    idx1 = idx1 - 1;
  end
  always @(negedge cs_n2) idx2 = 15;
  always @(negedge sclk2) begin
    if (idx2 >= 0) sdo2 = word2[idx2];
    idx2 = idx2 - 1;
  end

  int vcnt = 0, vcyc = 0, verr = 0, ecnt = 0, vrun = 0, vmax = 0;
  logic [11:0] vdata = '0;
  int hirun = 0, gapn = 0;
  int gaps [64];
  always @(negedge clk) begin
    if (valid) begin
      vcnt++;
      vcyc = cyc;
      vdata = data;
      verr = int'(ferr);
      vrun++;
      if (vrun > vmax) vmax = vrun;
    end else begin
      vrun = 0;
    end
    if (ferr) ecnt++;
    if (cs_n) begin
      hirun++;
    end else begin
      if (hirun != 0) begin
        if (gapn < 64) gaps[gapn] = hirun;
        gapn++;
      end
      hirun = 0;
    end
  end

  int vcnt2 = 0, vcyc2 = 0, lowrun = 0, lowpulses = 0, badrun = 0;
  logic [11:0] vdata2 = '0;
  always @(negedge clk) begin
    if (valid2) begin
      vcnt2++;
      vcyc2 = cyc;
      vdata2 = data2;
    end
    if (!sclk2) begin
      lowrun++;
    end else if (lowrun != 0) begin
      lowpulses++;
      if (lowrun != 1) badrun++;
      lowrun = 0;
    end
  end

  int nchk = 0;
  int nerr = 0;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    nchk++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic kick1(output int e0);
    @(negedge clk) start = 1'b1;
    @(posedge clk);
    #1 e0 = cyc;
    @(negedge clk) start = 1'b0;
  endtask

  task automatic kick2(output int e0);
    @(negedge clk) start2 = 1'b1;
    @(posedge clk);
    #1 e0 = cyc;
    @(negedge clk) start2 = 1'b0;
  endtask

  task automatic wait_v(input bit second, input int target, input int budget);
    int n = 0;
    while ((second ? vcnt2 : vcnt) < target && n < budget) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    check("wait_valid", second ? vcnt2 : vcnt, target);
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    while (busy && n < budget) begin
      @(negedge clk);
      n++;
    end
    check("wait_idle", {31'd0, busy}, 32'd0);
  endtask

  int e0, e2, g0, b, dummy;

  initial begin
    repeat (3) @(negedge clk);
    check("rst_cs_n", {31'd0, cs_n}, 1);
    check("rst_sclk", {31'd0, sclk}, 1);
    check("rst_data", {20'd0, data}, 0);
    check("rst_valid", {31'd0, valid}, 0);
    check("rst_ferr", {31'd0, ferr}, 0);
    check("rst_busy", {31'd0, busy}, 0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    word1 = 16'h0AC3;
    kick1(e0);
    check("t1_cs_low", {31'd0, cs_n}, 0);
    check("t1_busy", {31'd0, busy}, 1);
    check("t1_sclk_setup", {31'd0, sclk}, 1);
    wait_v(0, 1, 400);
    check("t1_data", {20'd0, vdata}, 32'h0AC3);
    check("t1_latency", vcyc - e0, 136);
    check("t1_ferr", verr, 0);
    repeat (20) @(negedge clk);
    check("t1_hold", {20'd0, data}, 32'h0AC3);
    check("t1_pulses", vcnt, 1);

    word2 = 16'h0AC3;
    kick2(e2);
    wait_v(1, 1, 200);
    check("d1_data", {20'd0, vdata2}, 32'h0AC3);
    check("d1_latency", vcyc2 - e2, 34);
    check("d1_low_pulses", lowpulses, 16);
    check("d1_bad_width", badrun, 0);

    wait_idle(50);
    word1 = 16'h8FFF;
    kick1(e0);
    wait_v(0, 2, 400);
    check("t2_data", {20'd0, vdata}, 32'h0FFF);
    check("t2_ferr", verr, 1);
    check("t2_ferr_cnt", ecnt, 1);
    check("t2_latency", vcyc - e0, 136);

    wait_idle(50);
    repeat (5) @(negedge clk);
    word1 = 16'h0AC3;
    g0 = gapn;
    start = 1'b1;
    wait_v(0, 5, 1000);
    start = 1'b0;
    check("t3_frames", vcnt, 5);
    check("t3_gap1", gaps[(g0 + 1) % 64], 9);
    check("t3_gap2", gaps[(g0 + 2) % 64], 9);
    check("t3_data", {20'd0, vdata}, 32'h0AC3);
    wait_idle(50);

    kick1(e0);
    repeat (20) @(negedge clk);
    kick1(dummy);
    repeat (30) @(negedge clk);
    kick1(dummy);
    wait_v(0, 6, 400);
    repeat (200) @(negedge clk);
    check("t3_no_queue", vcnt, 6);

    kick1(e0);
    repeat (60) @(posedge clk);
    #1 rst = 1'b1;
    #1;
    check("t4_cs_n", {31'd0, cs_n}, 1);
    check("t4_sclk", {31'd0, sclk}, 1);
    check("t4_data", {20'd0, data}, 0);
    check("t4_busy", {31'd0, busy}, 0);
    b = vcnt;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    repeat (20) @(negedge clk);
    check("t4_no_valid", vcnt, b);
    check("t4_data_held0", {20'd0, data}, 0);
    kick1(e0);
    wait_v(0, b + 1, 400);
    check("t4_data_new", {20'd0, vdata}, 32'h0AC3);
    check("t4_latency", vcyc - e0, 136);
    check("valid_width", vmax, 1);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
